// File: rtl/pipelined_alu.sv
// Handshaked ALU: single-cycle logic/arithmetic ops with registered result and flags.
// Define PIPELINED_ALU_MUL_EN to add the iterative shift-add multiplier (code 1000).
module pipelined_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;
`ifdef PIPELINED_ALU_MUL_EN
  localparam logic [3:0] CTL_MUL = 4'b1000;
`endif

  logic [WIDTH-1:0] op_res;
  logic             op_ovf;
  logic             op_illegal;
  logic             fire;
`ifdef PIPELINED_ALU_MUL_EN
  logic             op_is_mul;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    op_res     = '0;
    op_ovf     = 1'b0;
    op_illegal = 1'b0;
`ifdef PIPELINED_ALU_MUL_EN
    op_is_mul  = 1'b0;
`endif
    case (alu_ctl)
      CTL_AND: op_res = a & b;
      CTL_OR:  op_res = a | b;
      CTL_ADD: begin
        op_res = a + b;
        op_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
      end
      CTL_SUB: begin
        op_res = a - b;
        op_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
      end
      CTL_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      CTL_NOR: op_res = ~(a | b);
`ifdef PIPELINED_ALU_MUL_EN
      CTL_MUL: op_is_mul = 1'b1;
`endif
      default: op_illegal = 1'b1;
    endcase
  end

  assign fire = in_valid && in_ready;

`ifdef PIPELINED_ALU_MUL_EN

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_HOLD
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers use <= so each one samples pre-edge values whatever the statement order.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && op_is_mul) state_nxt = S_MUL;
      end
      S_MUL:   if (cnt == '0) state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Carry out of the high-half add becomes the top bit after the right shift.
  assign addend  = mplier[0] ? mcand : '0;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire && op_is_mul) begin
            mcand     <= a;
            mplier    <= b;
            acc       <= '0;
            cnt       <= CW'(WIDTH);
            out_valid <= 1'b0;
          end else if (fire) begin
            result    <= op_res;
            result_hi <= '0;
            zero      <= (op_res == '0);
            ovf       <= op_ovf;
            illegal   <= op_illegal;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            result    <= acc[WIDTH-1:0];
            result_hi <= acc[2*WIDTH-1:WIDTH];
            zero      <= (acc[WIDTH-1:0] == '0);
            ovf       <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            acc    <= {mul_sum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
          end
        end
        S_HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`else

  assign in_ready  = !out_valid || out_ready;
  assign result_hi = '0;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers use <= so each one samples pre-edge values whatever the statement order.
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else if (fire) begin
      result    <= op_res;
      zero      <= (op_res == '0);
      ovf       <= op_ovf;
      illegal   <= op_illegal;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: doc/pipelined_alu.md
# pipelined_alu

Parametrised, handshaked successor to the team's combinational 32-bit ALU. It accepts an operand pair plus a 4-bit ALU control code through a valid/ready input port and returns a registered result with flags through a valid/ready output port. Single-cycle operations complete with 1-cycle latency. An optional iterative shift-add multiplier takes WIDTH+1 cycles. It sits between the decode stage, which drives `alu_ctl` from the existing ALU-control decoder, and the writeback stage.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  operand/control bundle valid.
- `in_ready`  out  1  block can accept the bundle this cycle.
- `alu_ctl`  in  4  operation code, same encoding as the existing ALU control.
- `a`, `b`  in  WIDTH  operands.
- `out_valid`  out  1  result bundle valid.
- `out_ready`  in  1  downstream consumes the bundle this cycle.
- `result`  out  WIDTH  result; low half for MUL.
- `result_hi`  out  WIDTH  high half of MUL product; 0 for all other operations.
- `zero`  out  1  `result == 0`.
- `ovf`  out  1  signed overflow; ADD/SUB only, otherwise 0.
- `illegal`  out  1  `alu_ctl` was not a supported code.

## Operation
- Codes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0110 SUB (a−b).
  - 0111 SLT: signed; result is 1 if a<b, else 0.
  - 1100 NOR.
  - 1000 MUL: unsigned, 2·WIDTH-bit product.
- Any other code completes as a single-cycle operation with `result`=0, `zero`=1, `illegal`=1.
- Arithmetic is modulo 2^WIDTH. `ovf` is set when the operand signs match (ADD) or differ (SUB) and the result sign differs from `a`.
- The FSM has three states: IDLE, MUL, HOLD.
  - IDLE: `in_ready` = !`out_valid` | `out_ready`.
  - IDLE, handshake on a single-cycle code: the result register loads and `out_valid` goes to 1 at the same edge. The FSM stays in IDLE, so back-to-back throughput is 1 op/cycle when `out_ready` is held at 1.
  - IDLE, handshake on MUL: latch a and b, clear the accumulator, set the counter to WIDTH, go to MUL. If the old result is being consumed on this edge, `out_valid` drops.
  - MUL: `in_ready`=0. Each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator high half; then shift right; then decrement the counter. When the counter reaches 0, load `result`/`result_hi`/flags, set `out_valid`, and go to HOLD.
  - HOLD: `in_ready`=0. When `out_ready`=1, drop `out_valid` and go to IDLE.
- Output bundle stability: `result`, `result_hi`, the flags and `out_valid` stay stable while `out_valid`=1 and `out_ready`=0.
- Inputs are sampled only on the handshake edge.
- `in_valid` while `in_ready`=0 is ignored, with no side effect.

## Timing
- Reset values:
  - `out_valid`=0.
  - `result`=0, `result_hi`=0.
  - `zero`=0, `ovf`=0, `illegal`=0.
  - State=IDLE, counter=0.
  - `in_ready`=1 once `reset` deasserts.
- Single-cycle ops:
  - Handshake at edge N, so `out_valid`=1 after edge N.
  - Consumed at edge N+1 if `out_ready`=1.
- MUL:
  - Handshake at edge N.
  - `out_valid`=1 after edge N+WIDTH+1.
  - Return to IDLE at the edge where `out_ready`=1.
  - The earliest next acceptance is the cycle after the HOLD→IDLE edge.
- Simultaneous events:
  - Consume and accept on the same IDLE edge: the new single-cycle result replaces the old one with no bubble.
  - For MUL, `out_valid` falls.
- Reset asserted mid-MUL or in HOLD:
  - The operation is abandoned and outputs go to their reset values asynchronously.
  - No result is emitted after release.
- MUL latency does not depend on operand values. There is no early termination.

## Configuration
- `PIPELINED_ALU_MUL_EN` defined:
  - MUL (1000) is implemented as above.
  - The MUL and HOLD states and the 2·WIDTH accumulator exist.
- `PIPELINED_ALU_MUL_EN` undefined:
  - 1000 is treated as illegal: single-cycle completion with `result`=0, `illegal`=1.
  - MUL and HOLD states, the counter and the accumulator are not synthesised.
  - `result_hi` is tied to 0.

## Test plan
- Reset and first op:
  - Assert `reset` for 3 cycles and check `out_valid`=0 and `result`=0.
  - Release, then ADD a=5, b=7 → `result`=12 one cycle later, `zero`=0, `ovf`=0.
- Overflow and flags (WIDTH=32):
  - ADD 0x7FFFFFFF+1 → `result`=0x80000000, `ovf`=1.
  - SUB 3−3 → 0, `zero`=1.
  - SLT −1<1 → 1.
  - NOR 0,0 → 0xFFFFFFFF.
- Backpressure:
  - Issue OR 0xF0,0x0F with `out_ready`=0 for 5 cycles.
  - Check `result`=0xFF is held stable and `in_ready`=0.
  - Then `out_ready`=1 with AND queued → back-to-back acceptance, no bubble.
- MUL (macro on):
  - 0xFFFFFFFF×0xFFFFFFFF → `out_valid` exactly 33 cycles after handshake, `result`=0x00000001, `result_hi`=0xFFFFFFFE.
  - `in_ready`=0 throughout.
- Reset mid-MUL:
  - Start MUL 6×7, assert `reset` at cycle 10.
  - Check that no `out_valid` pulse follows.
  - A subsequent ADD 1+1 → 2.
- Illegal and macro off:
  - Code 0101 → `result`=0, `illegal`=1, `zero`=1.
  - Without the macro, code 1000 gives the same response with 1-cycle latency.
